// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with count, level flags, FWFT option, flush and sticky errors
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              signal_write,
  input  logic [DATA_W-1:0] write_data,
  input  logic              signal_read,
  input  logic              flush,
  input  logic              clr_err,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   cnt;
  logic              wr_ok;
  logic              rd_ok;

  // Flags decode only the registered count, so no input reaches them combinationally.
  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;

  assign wr_ok = signal_write & ~full & ~flush;
  assign rd_ok = signal_read & ~empty & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
      else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
    end
  end

  // Set is evaluated after clear so a coincident error wins over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      if (!flush && signal_write && full) overflow  <= 1'b1;
      if (!flush && signal_read && empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= write_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign read_data = empty ? '0 : mem[rptr[ADDR_W-1:0]];
    end else begin : g_reg
      logic [DATA_W-1:0] rd_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)       rd_q <= '0;
        else if (rd_ok) rd_q <= mem[rptr[ADDR_W-1:0]];
      end
      assign read_data = rd_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench driving a registered-read and an FWFT instance in lockstep
module tb_sync_fifo_param;

  logic       clk;
  logic       rst_n;
  logic       signal_write;
  logic [7:0] write_data;
  logic       signal_read;
  logic       flush;
  logic       clr_err;

  logic [7:0] rd0, rd1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0] cnt0, cnt1;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q [$];
  logic       mon_take;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst_n), .signal_write(signal_write), .write_data(write_data),
    .signal_read(signal_read), .flush(flush), .clr_err(clr_err), .read_data(rd0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst_n), .signal_write(signal_write), .write_data(write_data),
    .signal_read(signal_read), .flush(flush), .clr_err(clr_err), .read_data(rd1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    signal_write = w; write_data = d; signal_read = r; flush = f; clr_err = c;
    @(posedge clk); #1;
    signal_write = 1'b0; signal_read = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] exp);
    exp_q.push_back(exp);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clr();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Registered-read data is due just after the edge that accepted the read.
  always @(posedge clk) begin
    mon_take = rst_n && signal_read && !empty0 && !flush;
    #2;
    if (mon_take) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got 0x%0h expected no read at %0t", rd0, $time);
      end else begin
        check("sb_rdata", {24'h0, rd0}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b1; signal_write = 1'b0; write_data = 8'h00;
    signal_read = 1'b0; flush = 1'b0; clr_err = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_count", cnt0, 0);
    check("rst_ae", ae0, 1);
    check("rst_af", af0, 0);
    check("rst_rdata0", rd0, 0);
    check("rst_rdata1", rd1, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_unf", unf0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("empty_rd_unf", unf0, 1);
    check("empty_rd_count", cnt0, 0);
    clr();
    check("clr_unf", unf0, 0);

    for (int k = 1; k <= 8; k++) begin
      wr(8'(k));
      check("fill_count", cnt0, k);
      check("fill_af", af0, (k >= 6));
      check("fill_ae", ae0, (k <= 2));
      check("fill_full", full0, (k == 8));
    end
    wr(8'd9);
    check("ovf_set", ovf0, 1);
    check("ovf_count", cnt0, 8);
    for (int k = 1; k <= 8; k++) begin
      check("fwft_head", rd1, k);
      rd(8'(k));
    end
    check("drain_empty", empty0, 1);
    check("drain_ovf_sticky", ovf0, 1);
    clr();

    for (int k = 0; k < 8; k++) wr(8'(16 + k));
    step(1'b1, 8'd99, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'd16);
    check("full_rw_count", cnt0, 7);
    check("full_rw_ovf", ovf0, 1);
    for (int k = 1; k < 8; k++) rd(8'(16 + k));
    check("full_rw_drained", empty0, 1);
    clr();
    step(1'b1, 8'd42, 1'b1, 1'b0, 1'b0);
    check("empty_rw_count", cnt0, 1);
    check("empty_rw_unf", unf0, 1);
    check("empty_rw_fwft", rd1, 42);
    rd(8'd42);
    clr();

    for (int k = 0; k < 20; k++) begin
      wr(8'(100 + k));
      check("alt_count1", cnt0, 1);
      rd(8'(100 + k));
      check("alt_count0", cnt0, 0);
    end

    check("fwft_empty_zero", rd1, 0);
    wr(8'h5A);
    check("fwft_first", rd1, 8'h5A);
    rd(8'h5A);
    check("fwft_pop_empty", empty1, 1);
    check("fwft_pop_zero", rd1, 0);
    wr(8'h11); wr(8'h22); wr(8'h33);
    check("fwft_b0", rd1, 8'h11); rd(8'h11);
    check("fwft_b1", rd1, 8'h22); rd(8'h22);
    check("fwft_b2", rd1, 8'h33); rd(8'h33);

    for (int k = 1; k <= 5; k++) wr(8'(k));
    check("pre_flush_count", cnt0, 5);
    step(1'b1, 8'd77, 1'b1, 1'b1, 1'b0);
    check("flush_count", cnt0, 0);
    check("flush_empty", empty0, 1);
    check("flush_ovf", ovf0, 0);
    check("flush_unf", unf0, 0);
    check("flush_rdata_hold", rd0, 8'h33);
    check("flush_fwft_zero", rd1, 0);

    for (int k = 1; k <= 8; k++) wr(8'(k));
    step(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    check("set_wins_ovf", ovf0, 1);
    clr();
    check("clr_ovf", ovf0, 0);

    signal_write = 1'b1; write_data = 8'h55; signal_read = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_count", cnt0, 0);
    check("arst_empty", empty0, 1);
    check("arst_full", full0, 0);
    check("arst_ae", ae0, 1);
    check("arst_ovf", ovf0, 0);
    check("arst_rdata0", rd0, 0);
    check("arst_rdata1", rd1, 0);
    signal_write = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    repeat (2) @(posedge clk);
    #3;
    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
